// File: rtl/typed_operand_stack.sv
// rtl/typed_operand_stack.sv - typed {type,value} operand stack with registered top-three view and sticky errors
// Optional high-water-mark output enabled by defining TYPED_STACK_HWM_EN.
module typed_operand_stack #(
    parameter int VALUE_W = 64,
    parameter int TYPE_W  = 2,
    parameter int DEPTH   = 8,
    localparam int EW     = TYPE_W + VALUE_W,
    localparam int ADDR_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [EW-1:0]     op_data,
    output logic              op_ready,
    output logic [EW-1:0]     tos0,
    output logic [EW-1:0]     tos1,
    output logic [EW-1:0]     tos2,
    output logic [ADDR_W-1:0] count,
`ifdef TYPED_STACK_HWM_EN
    output logic [ADDR_W-1:0] hwm,
`endif
    output logic              empty,
    output logic              full,
    output logic              err_valid,
    output logic [2:0]        err_code,
    input  logic              err_clr
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_BINREP  = 3'd4;
    localparam logic [2:0] OP_SELECT  = 3'd5;
    localparam logic [2:0] OP_POP2    = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    localparam logic [2:0] ERR_OVERFLOW  = 3'd1;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_TYPE      = 3'd3;
    localparam logic [2:0] ERR_ILLEGAL   = 3'd4;

    logic [EW-1:0]     mem [DEPTH];
    logic              accept;
    logic              fault;
    logic [2:0]        fault_code;
    logic              do_op;
    logic [ADDR_W-1:0] count_nx;
    logic [EW-1:0]     tos0_nx, tos1_nx, tos2_nx;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [EW-1:0]     wr_data;
    logic [EW-1:0]     fill4, fill5;
    logic [EW-1:0]     sel_result;
    logic [IDX_W-1:0]  idx4, idx5;

    assign op_ready = !err_valid;
    assign accept   = op_valid && op_ready && (op != OP_NONE);
    assign empty    = (count == '0);
    assign full     = (count == ADDR_W'(DEPTH));

    // Entries below the visible three, used to refill tos1/tos2 on pops without a bubble.
    assign idx4  = count[IDX_W-1:0] - IDX_W'(4);
    assign idx5  = count[IDX_W-1:0] - IDX_W'(5);
    assign fill4 = (count >= ADDR_W'(4)) ? mem[idx4] : '0;
    assign fill5 = (count >= ADDR_W'(5)) ? mem[idx5] : '0;

    assign sel_result = (tos0[VALUE_W-1:0] != '0) ? tos2 : tos1;

    always_comb begin
        fault      = 1'b0;
        fault_code = 3'd0;
        unique case (op)
            OP_NONE:    ;
            OP_PUSH:    if (count >= ADDR_W'(DEPTH)) begin fault = 1'b1; fault_code = ERR_OVERFLOW; end
            OP_POP,
            OP_REPLACE: if (count < ADDR_W'(1)) begin fault = 1'b1; fault_code = ERR_UNDERFLOW; end
            OP_BINREP,
            OP_POP2:    if (count < ADDR_W'(2)) begin fault = 1'b1; fault_code = ERR_UNDERFLOW; end
            OP_SELECT: begin
                if (count < ADDR_W'(3)) begin
                    fault = 1'b1; fault_code = ERR_UNDERFLOW;
                end else if (tos2[EW-1 -: TYPE_W] != tos1[EW-1 -: TYPE_W]) begin
                    fault = 1'b1; fault_code = ERR_TYPE;
                end
            end
            OP_CLEAR:   ;
            default:    begin fault = 1'b1; fault_code = ERR_ILLEGAL; end
        endcase
    end

    assign do_op = accept && !fault;

    always_comb begin
        count_nx = count;
        tos0_nx  = tos0;
        tos1_nx  = tos1;
        tos2_nx  = tos2;
        wr_en    = 1'b0;
        wr_idx   = count[IDX_W-1:0];
        wr_data  = op_data;
        if (do_op) begin
            unique case (op)
                OP_PUSH: begin
                    count_nx = count + ADDR_W'(1);
                    tos0_nx  = op_data;
                    tos1_nx  = tos0;
                    tos2_nx  = tos1;
                    wr_en    = 1'b1;
                end
                OP_POP: begin
                    count_nx = count - ADDR_W'(1);
                    tos0_nx  = tos1;
                    tos1_nx  = tos2;
                    tos2_nx  = fill4;
                end
                OP_REPLACE: begin
                    tos0_nx = op_data;
                    wr_en   = 1'b1;
                    wr_idx  = count[IDX_W-1:0] - IDX_W'(1);
                end
                OP_BINREP: begin
                    count_nx = count - ADDR_W'(1);
                    tos0_nx  = op_data;
                    tos1_nx  = tos2;
                    tos2_nx  = fill4;
                    wr_en    = 1'b1;
                    wr_idx   = count[IDX_W-1:0] - IDX_W'(2);
                end
                OP_SELECT: begin
                    count_nx = count - ADDR_W'(2);
                    tos0_nx  = sel_result;
                    tos1_nx  = fill4;
                    tos2_nx  = fill5;
                    wr_en    = 1'b1;
                    wr_idx   = count[IDX_W-1:0] - IDX_W'(3);
                    wr_data  = sel_result;
                end
                OP_POP2: begin
                    count_nx = count - ADDR_W'(2);
                    tos0_nx  = tos2;
                    tos1_nx  = fill4;
                    tos2_nx  = fill5;
                end
                OP_CLEAR: begin
                    count_nx = '0;
                    tos0_nx  = '0;
                    tos1_nx  = '0;
                    tos2_nx  = '0;
                end
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries beyond count are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tos0  <= '0;
            tos1  <= '0;
            tos2  <= '0;
        end else begin
            count <= count_nx;
            tos0  <= tos0_nx;
            tos1  <= tos1_nx;
            tos2  <= tos2_nx;
        end
    end

    // Clear wins over set; a new fault cannot coincide since op_ready is low while flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_valid <= 1'b0;
            err_code  <= 3'd0;
        end else if (err_valid && err_clr) begin
            err_valid <= 1'b0;
            err_code  <= 3'd0;
        end else if (accept && fault) begin
            err_valid <= 1'b1;
            err_code  <= fault_code;
        end
    end

`ifdef TYPED_STACK_HWM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwm <= '0;
        end else if (do_op && op == OP_CLEAR) begin
            hwm <= '0;
        end else if (count_nx > hwm) begin
            hwm <= count_nx;
        end
    end
`endif

endmodule

// File: tb/tb_typed_operand_stack.sv
// tb/tb_typed_operand_stack.sv - scoreboard bench for typed_operand_stack
// Expected snapshots are queued by the driver and checked by an independent monitor.
module tb_typed_operand_stack;
    localparam int EW = 66;

    typedef struct packed {
        logic [3:0]    cnt;
        logic [EW-1:0] t0;
        logic [EW-1:0] t1;
        logic [EW-1:0] t2;
        logic          ev;
        logic [2:0]    ec;
        logic          rdy;
        logic          emp;
        logic          ful;
    } snap_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [EW-1:0] op_data = '0;
    logic          err_clr = 1'b0;
    logic          op_ready, empty, full, err_valid;
    logic [EW-1:0] tos0, tos1, tos2;
    logic [3:0]    count;
    logic [2:0]    err_code;
`ifdef TYPED_STACK_HWM_EN
    logic [3:0]    hwm;
`endif

    typed_operand_stack dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_data(op_data),
        .op_ready(op_ready), .tos0(tos0), .tos1(tos1), .tos2(tos2), .count(count),
`ifdef TYPED_STACK_HWM_EN
        .hwm(hwm),
`endif
        .empty(empty), .full(full), .err_valid(err_valid), .err_code(err_code),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    snap_t exp_q[$];
    int    due_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    function automatic logic [EW-1:0] e(input int t, input int v);
        logic [1:0]  tt;
        logic [63:0] vv;
        tt = 2'(t);
        vv = 64'(v);
        return {tt, vv};
    endfunction

    function automatic snap_t mk(input int c, input logic [EW-1:0] a, input logic [EW-1:0] b,
                                 input logic [EW-1:0] d, input logic ev, input int ec);
        snap_t s;
        s.cnt = 4'(c); s.t0 = a; s.t1 = b; s.t2 = d;
        s.ev = ev; s.ec = 3'(ec); s.rdy = !ev;
        s.emp = (c == 0); s.ful = (c == 8);
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s.cnt = count; s.t0 = tos0; s.t1 = tos1; s.t2 = tos2;
        s.ev = err_valid; s.ec = err_code; s.rdy = op_ready; s.emp = empty; s.ful = full;
        return s;
    endfunction

    task automatic check(input string nm, input snap_t g, input snap_t x);
        n_checks++;
        if (g === x) n_pass++;
        else $display("FAIL %s: got cnt=%0d t0=%h t1=%h t2=%h ev=%b ec=%0d rdy=%b e=%b f=%b; want cnt=%0d t0=%h t1=%h t2=%h ev=%b ec=%0d rdy=%b e=%b f=%b",
                      nm, g.cnt, g.t0, g.t1, g.t2, g.ev, g.ec, g.rdy, g.emp, g.ful,
                      x.cnt, x.t0, x.t1, x.t2, x.ev, x.ec, x.rdy, x.emp, x.ful);
    endtask

    task automatic step(input logic v, input logic [2:0] o, input logic [EW-1:0] d,
                        input logic clr, input string nm, input snap_t x);
        @(posedge clk);
        #1;
        op_valid = v; op = o; op_data = d; err_clr = clr;
        exp_q.push_back(x);
        due_q.push_back(cyc + 1);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = 3'd0; op_data = '0; err_clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && due_q.size() > 0; i++) @(posedge clk);
        if (due_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d snapshots still pending, want 0", due_q.size());
            exp_q.delete(); due_q.delete(); name_q.delete();
        end
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #3;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                check(name_q[0], observe(), exp_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
                void'(name_q.pop_front());
            end
        end
    end

    localparam logic [2:0] NONE = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                           BIN = 3'd4, SEL = 3'd5, POP2 = 3'd6, CLR = 3'd7;

    initial begin : driver
        logic [EW-1:0] z;
        z = '0;
        #12;
        check("reset_state", observe(), mk(0, z, z, z, 0, 0));
        @(posedge clk);
        #1 reset = 1'b1;

        step(1, PUSH, e(1, 5), 0, "push5", mk(1, e(1, 5), z, z, 0, 0));
        step(1, PUSH, e(1, 6), 0, "push6", mk(2, e(1, 6), e(1, 5), z, 0, 0));
        step(1, PUSH, e(1, 7), 0, "push7", mk(3, e(1, 7), e(1, 6), e(1, 5), 0, 0));
        step(1, PUSH, e(1, 8), 0, "push8", mk(4, e(1, 8), e(1, 7), e(1, 6), 0, 0));
        step(1, PUSH, e(1, 9), 0, "push9", mk(5, e(1, 9), e(1, 8), e(1, 7), 0, 0));
        step(1, PUSH, e(1, 10), 0, "push10", mk(6, e(1, 10), e(1, 9), e(1, 8), 0, 0));
        step(1, PUSH, e(1, 11), 0, "push11_not_full", mk(7, e(1, 11), e(1, 10), e(1, 9), 0, 0));
        step(1, PUSH, e(1, 12), 0, "push12_full", mk(8, e(1, 12), e(1, 11), e(1, 10), 0, 0));
        step(1, PUSH, e(1, 13), 0, "overflow", mk(8, e(1, 12), e(1, 11), e(1, 10), 1, 1));
        step(1, POP, z, 0, "ignored_in_err", mk(8, e(1, 12), e(1, 11), e(1, 10), 1, 1));
        step(0, NONE, z, 1, "err_clr", mk(8, e(1, 12), e(1, 11), e(1, 10), 0, 0));
        step(1, POP, z, 0, "pop_refill", mk(7, e(1, 11), e(1, 10), e(1, 9), 0, 0));
        step(1, POP2, z, 0, "pop2_refill", mk(5, e(1, 9), e(1, 8), e(1, 7), 0, 0));
        step(1, BIN, e(2, 100), 0, "binrep", mk(4, e(2, 100), e(1, 7), e(1, 6), 0, 0));
        step(1, REPL, e(2, 55), 0, "replace", mk(4, e(2, 55), e(1, 7), e(1, 6), 0, 0));
        step(1, POP2, z, 0, "pop2_after_binrep", mk(2, e(1, 6), e(1, 5), z, 0, 0));
        step(1, CLR, z, 0, "clear", mk(0, z, z, z, 0, 0));
        step(1, POP, z, 0, "underflow_pop", mk(0, z, z, z, 1, 2));
        step(0, NONE, z, 1, "err_clr2", mk(0, z, z, z, 0, 0));
        step(1, REPL, e(1, 9), 0, "underflow_replace", mk(0, z, z, z, 1, 2));
        step(0, NONE, z, 1, "err_clr3", mk(0, z, z, z, 0, 0));
        step(1, PUSH, e(1, 1), 0, "push1", mk(1, e(1, 1), z, z, 0, 0));
        step(1, REPL, e(1, 42), 0, "replace_new", mk(1, e(1, 42), z, z, 0, 0));
        step(1, POP2, z, 0, "pop2_underflow", mk(1, e(1, 42), z, z, 1, 2));
        step(0, NONE, z, 1, "err_clr4", mk(1, e(1, 42), z, z, 0, 0));
        step(1, NONE, e(1, 77), 0, "none_valid", mk(1, e(1, 42), z, z, 0, 0));
        step(1, CLR, z, 0, "clear2", mk(0, z, z, z, 0, 0));
        step(1, PUSH, e(0, 10), 0, "sel_a", mk(1, e(0, 10), z, z, 0, 0));
        step(1, PUSH, e(0, 20), 0, "sel_b", mk(2, e(0, 20), e(0, 10), z, 0, 0));
        step(1, PUSH, e(0, 1), 0, "sel_c1", mk(3, e(0, 1), e(0, 20), e(0, 10), 0, 0));
        step(1, SEL, z, 0, "select_true", mk(1, e(0, 10), z, z, 0, 0));
        step(1, CLR, z, 0, "clear3", mk(0, z, z, z, 0, 0));
        step(1, PUSH, e(1, 99), 0, "sel_z", mk(1, e(1, 99), z, z, 0, 0));
        step(1, PUSH, e(0, 10), 0, "sel_a2", mk(2, e(0, 10), e(1, 99), z, 0, 0));
        step(1, PUSH, e(0, 20), 0, "sel_b2", mk(3, e(0, 20), e(0, 10), e(1, 99), 0, 0));
        step(1, PUSH, e(0, 0), 0, "sel_c0", mk(4, e(0, 0), e(0, 20), e(0, 10), 0, 0));
        step(1, SEL, z, 0, "select_false", mk(2, e(0, 20), e(1, 99), z, 0, 0));
        step(1, CLR, z, 0, "clear4", mk(0, z, z, z, 0, 0));
        step(1, PUSH, e(0, 10), 0, "mm_a", mk(1, e(0, 10), z, z, 0, 0));
        step(1, PUSH, e(1, 20), 0, "mm_b", mk(2, e(1, 20), e(0, 10), z, 0, 0));
        step(1, PUSH, e(0, 1), 0, "mm_c", mk(3, e(0, 1), e(1, 20), e(0, 10), 0, 0));
        step(1, SEL, z, 0, "select_mismatch", mk(3, e(0, 1), e(1, 20), e(0, 10), 1, 3));
        step(1, PUSH, e(0, 5), 1, "clr_beats_op", mk(3, e(0, 1), e(1, 20), e(0, 10), 0, 0));
        step(1, PUSH, e(0, 4), 0, "push_after_clr", mk(4, e(0, 4), e(0, 1), e(1, 20), 0, 0));
        idle();
        drain();

        @(posedge clk);
        #1;
        op_valid = 1'b1; op = PUSH; op_data = e(1, 3);
        reset = 1'b0;
        #1;
        check("async_reset", observe(), mk(0, z, z, z, 0, 0));
`ifdef TYPED_STACK_HWM_EN
        n_checks++;
        if (hwm === 4'd0) n_pass++;
        else $display("FAIL hwm_reset: got %0d want 0", hwm);
`endif
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_in_reset", observe(), mk(0, z, z, z, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
